keypad_scanner: RTL and testbench

- Memory-mapped responder for the CPU's keypad read port: scans a 4x4 key matrix, debounces presses and latches a 4-bit key code.
- Presents either a status word or the key code on `keyout`, selected by `statusordata`.
- Clears its pending-key status when the top level asserts `ack`, which happens on a CPU read of the data address.
- Sits between the board matrix pins (`rowwrite`/`colread`) and the top-level CPU input multiplexer.

---
 rtl/keypad_scanner.sv | 215 +++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// 4x4 keypad matrix scanner: row drive, debounce, latched key code and a status/data read port.
// Define KEYPAD_AUTOREPEAT_EN to re-latch a continuously held key every REPEAT_TICKS scan ticks.
module keypad_scanner #(
   parameter int SCAN_DIV     = 50000,
   parameter int DEBOUNCE_CNT = 4,
   parameter int REPEAT_TICKS = 64
) (
   input  logic       clk,
   input  logic       rst_n,
   output logic [3:0] rowwrite,
   input  logic [3:0] colread,
   input  logic       ack,
   input  logic       statusordata,
   output logic [3:0] keyout
);

   localparam int PRE_W = $clog2(SCAN_DIV);
   localparam int DEB_W = $clog2(DEBOUNCE_CNT + 1);
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
   localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CNT);

   localparam logic [1:0] ST_SCAN     = 2'd0;
   localparam logic [1:0] ST_DEBOUNCE = 2'd1;
   localparam logic [1:0] ST_HOLD     = 2'd2;

   if (SCAN_DIV < 2 || DEBOUNCE_CNT < 2 || REPEAT_TICKS < 1) begin : g_param_check
      $error("keypad_scanner: parameter below its minimum");
   end

   logic [PRE_W-1:0] pre_cnt;
   logic [PRE_W-1:0] pre_nxt;
   logic             tick;

   logic [1:0]       state;
   logic [1:0]       state_nxt;
   logic [3:0]       row_nxt;
   logic [3:0]       row_rot;
   logic [3:0]       pattern;
   logic [3:0]       pat_nxt;
   logic [DEB_W-1:0] deb_cnt;
   logic [DEB_W-1:0] deb_nxt;
   logic [DEB_W-1:0] deb_inc;
   logic [DEB_W-1:0] rel_cnt;
   logic [DEB_W-1:0] rel_nxt;
   logic [DEB_W-1:0] rel_inc;

   logic [1:0]       row_idx;
   logic [1:0]       col_idx;
   logic [3:0]       new_code;
   logic             scan_latch;
   logic             latch_any;

   logic             ack_q;
   logic             ack_rise;
   logic [3:0]       key_code;
   logic             valid;
   logic             overrun;

   // Free-running prescaler; the FSM only moves on the tick cycle.
   always_comb begin
      tick    = (pre_cnt == PRE_LAST);
      pre_nxt = tick ? '0 : pre_cnt + 1'b1;
   end

   always_comb begin
      row_idx = 2'd0;
      case (rowwrite)
         4'b1101: row_idx = 2'd1;
         4'b1011: row_idx = 2'd2;
         4'b0111: row_idx = 2'd3;
         default: row_idx = 2'd0;
      endcase
      col_idx = 2'd0;
      if (!colread[0])      col_idx = 2'd0;
      else if (!colread[1]) col_idx = 2'd1;
      else if (!colread[2]) col_idx = 2'd2;
      else if (!colread[3]) col_idx = 2'd3;
      new_code = {row_idx, col_idx};
      row_rot  = {rowwrite[2:0], rowwrite[3]};
   end

   always_comb begin
      state_nxt  = state;
      row_nxt    = rowwrite;
      pat_nxt    = pattern;
      deb_nxt    = deb_cnt;
      rel_nxt    = rel_cnt;
      scan_latch = 1'b0;
      deb_inc    = deb_cnt + 1'b1;
      rel_inc    = rel_cnt + 1'b1;
      if (tick) begin
         case (state)
            ST_SCAN: begin
               if (colread == 4'hF) begin
                  row_nxt = row_rot;
               end else begin
                  pat_nxt   = colread;
                  deb_nxt   = DEB_W'(1);
                  state_nxt = ST_DEBOUNCE;
               end
            end
            ST_DEBOUNCE: begin
               if (colread == pattern) begin
                  deb_nxt = deb_inc;
                  if (deb_inc == DEB_LAST) begin
                     scan_latch = 1'b1;
                     rel_nxt    = '0;
                     state_nxt  = ST_HOLD;
                  end
               end else begin
                  row_nxt   = row_rot;
                  state_nxt = ST_SCAN;
               end
            end
            ST_HOLD: begin
               // A full debounced release is required before the next press can be seen.
               if (colread == 4'hF) begin
                  rel_nxt = rel_inc;
                  if (rel_inc == DEB_LAST) begin
                     rel_nxt   = '0;
                     row_nxt   = row_rot;
                     state_nxt = ST_SCAN;
                  end
               end else begin
                  rel_nxt = '0;
               end
            end
            default: begin
               row_nxt   = 4'b1110;
               state_nxt = ST_SCAN;
            end
         endcase
      end
   end

`ifdef KEYPAD_AUTOREPEAT_EN
   localparam int REP_W = $clog2(REPEAT_TICKS + 1);
   localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_TICKS);

   logic [REP_W-1:0] rep_cnt;
   logic [REP_W-1:0] rep_nxt;
   logic [REP_W-1:0] rep_inc;
   logic             rep_latch;

   always_comb begin
      rep_inc   = rep_cnt + 1'b1;
      rep_nxt   = '0;
      rep_latch = 1'b0;
      if (state == ST_HOLD) begin
         rep_nxt = rep_cnt;
         if (tick) begin
            if (colread == pattern) begin
               if (rep_inc == REP_LAST) begin
                  rep_latch = 1'b1;
                  rep_nxt   = '0;
               end else begin
                  rep_nxt = rep_inc;
               end
            end else begin
               rep_nxt = '0;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rep_cnt <= '0;
      else        rep_cnt <= rep_nxt;
   end

   assign latch_any = scan_latch | rep_latch;
`else
   assign latch_any = scan_latch;
`endif

   // Read handshake: ack is a level held high by the top-level decode for the
   // whole data read; only its rising edge consumes the pending key, so a long
   // or repeated read returns the same key_code with valid already cleared.
   assign ack_rise = ack & ~ack_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_cnt  <= '0;
         state    <= ST_SCAN;
         rowwrite <= 4'b1110;
         pattern  <= 4'hF;
         deb_cnt  <= '0;
         rel_cnt  <= '0;
         ack_q    <= 1'b0;
         key_code <= 4'h0;
         valid    <= 1'b0;
         overrun  <= 1'b0;
      end else begin
         pre_cnt  <= pre_nxt;
         state    <= state_nxt;
         rowwrite <= row_nxt;
         pattern  <= pat_nxt;
         deb_cnt  <= deb_nxt;
         rel_cnt  <= rel_nxt;
         ack_q    <= ack;
         // A latch beats a same-cycle ack: the old key counts as consumed.
         if (latch_any) begin
            key_code <= new_code;
            valid    <= 1'b1;
            overrun  <= ~ack_rise & (valid | overrun);
         end else if (ack_rise) begin
            valid    <= 1'b0;
            overrun  <= 1'b0;
         end
      end
   end

   assign keyout = statusordata ? {2'b00, overrun, valid} : key_code;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: a key-matrix model drives colread from rowwrite,
// a tick-aligned driver presses/releases keys, and expected key codes flow through exp_q.
module tb_keypad_scanner;

   localparam int SCAN_DIV     = 4;
   localparam int DEBOUNCE_CNT = 3;
   localparam int REPEAT_TICKS = 5;

`ifdef KEYPAD_AUTOREPEAT_EN
   localparam logic [3:0] HOLD_EXP = 4'b0011;
`else
   localparam logic [3:0] HOLD_EXP = 4'b0001;
`endif

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] rowwrite;
   logic [3:0] colread;
   logic       ack;
   logic       statusordata;
   logic [3:0] keyout;

   logic       key_down;
   logic [1:0] key_row;
   logic [1:0] key_col;

   int         checks = 0;
   int         failures = 0;
   int         ph = 0;
   logic [3:0] exp_q[$];

   always #5 clk = ~clk;

   keypad_scanner #(
      .SCAN_DIV     (SCAN_DIV),
      .DEBOUNCE_CNT (DEBOUNCE_CNT),
      .REPEAT_TICKS (REPEAT_TICKS)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .rowwrite     (rowwrite),
      .colread      (colread),
      .ack          (ack),
      .statusordata (statusordata),
      .keyout       (keyout)
   );

   // Key matrix: the pressed key pulls its column low only while its row is driven.
   always_comb begin
      colread = 4'hF;
      if (key_down && rowwrite[key_row] == 1'b0) colread[key_col] = 1'b0;
   end

   task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      ph++;
   endtask

   task automatic tick_step();
      do step(); while (ph % SCAN_DIV != 0);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick_step();
   endtask

   task automatic check_out(input string tag, input logic sod, input logic [3:0] exp);
      statusordata = sod;
      #1;
      chk(tag, keyout, exp);
   endtask

   function automatic logic [3:0] row_mask(input logic [1:0] r);
      logic [3:0] m;
      m = 4'hF;
      m[r] = 1'b0;
      return m;
   endfunction

   task automatic wait_row(input logic [3:0] target);
      int n = 0;
      while (rowwrite !== target && n < 8) begin
         tick_step();
         n++;
      end
      if (rowwrite !== target) chk("row_timeout", rowwrite, target);
   endtask

   task automatic press_key(input logic [1:0] r, input logic [1:0] c);
      wait_row(row_mask(r));
      key_row  = r;
      key_col  = c;
      key_down = 1'b1;
      ticks(DEBOUNCE_CNT);
   endtask

   task automatic release_key();
      key_down = 1'b0;
      ticks(DEBOUNCE_CNT);
   endtask

   task automatic ack_pulse();
      ack = 1'b1;
      step();
      ack = 1'b0;
      step();
   endtask

   task automatic read_data(input string tag);
      if (exp_q.size() == 0) chk("sb_underflow", 4'(exp_q.size()), 4'd1);
      else check_out(tag, 1'b0, exp_q.pop_front());
   endtask

   task automatic do_reset();
      rst_n    = 1'b0;
      key_down = 1'b0;
      ack      = 1'b0;
      #1;
      chk("rst_row", rowwrite, 4'b1110);
      check_out("rst_status", 1'b1, 4'h0);
      check_out("rst_data", 1'b0, 4'h0);
      step();
      step();
      rst_n = 1'b1;
      ph    = 0;
      #1;
      chk("rel_row", rowwrite, 4'b1110);
      check_out("rel_status", 1'b1, 4'h0);
      check_out("rel_data", 1'b0, 4'h0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached before the summary");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n        = 1'b0;
      ack          = 1'b0;
      statusordata = 1'b0;
      key_down     = 1'b0;
      key_row      = 2'd0;
      key_col      = 2'd0;
      @(negedge clk);
      do_reset();

      // Idle scan rotation, then reset in the middle of a tick period.
      tick_step();
      chk("scan_r1", rowwrite, 4'b1101);
      ticks(2);
      chk("scan_r3", rowwrite, 4'b0111);
      tick_step();
      chk("scan_wrap", rowwrite, 4'b1110);
      tick_step();
      step();
      do_reset();

      // Single press of row 2 col 1, held 20 ticks from detection.
      wait_row(4'b1011);
      key_row  = 2'd2;
      key_col  = 2'd1;
      key_down = 1'b1;
      exp_q.push_back(4'h9);
      tick_step();
      chk("det_row", rowwrite, 4'b1011);
      check_out("det_status", 1'b1, 4'h0);
      tick_step();
      check_out("deb_status", 1'b1, 4'h0);
      tick_step();
      check_out("latch_status", 1'b1, 4'b0001);
      read_data("latch_data");
      ticks(17);
      chk("hold_row", rowwrite, 4'b1011);
      check_out("hold_status", 1'b1, HOLD_EXP);
      key_down = 1'b0;
      ticks(2);
      chk("rel2_row", rowwrite, 4'b1011);
      tick_step();
      chk("rel3_row", rowwrite, 4'b0111);

      // Long ack level clears once; data stays readable.
      ack = 1'b1;
      step();
      check_out("ack_status", 1'b1, 4'h0);
      check_out("ack_data", 1'b0, 4'h9);
      repeat (9) step();
      check_out("ack_long_status", 1'b1, 4'h0);
      check_out("ack_long_data", 1'b0, 4'h9);
      ack = 1'b0;
      step();

      // Bounce: pattern seen for one tick only.
      wait_row(4'b1011);
      key_row  = 2'd2;
      key_col  = 2'd0;
      key_down = 1'b1;
      tick_step();
      key_down = 1'b0;
      tick_step();
      chk("bounce_row", rowwrite, 4'b0111);
      check_out("bounce_status", 1'b1, 4'h0);
      ticks(3);
      check_out("bounce_late", 1'b1, 4'h0);

      // Overrun: second latch without an intervening ack.
      exp_q.push_back(4'h9);
      press_key(2'd2, 2'd1);
      check_out("ovr_first_status", 1'b1, 4'b0001);
      read_data("ovr_first_data");
      release_key();
      exp_q.push_back(4'h3);
      press_key(2'd0, 2'd3);
      check_out("ovr_status", 1'b1, 4'b0011);
      read_data("ovr_data");
      ack_pulse();
      check_out("ovr_ack_status", 1'b1, 4'h0);
      check_out("ovr_ack_data", 1'b0, 4'h3);
      release_key();

      // Latch tick coincident with ack rise while an unread key is pending.
      exp_q.push_back(4'h6);
      press_key(2'd1, 2'd2);
      read_data("co_first_data");
      release_key();
      wait_row(4'b0111);
      key_row  = 2'd3;
      key_col  = 2'd3;
      key_down = 1'b1;
      exp_q.push_back(4'hF);
      ticks(2);
      repeat (3) step();
      ack = 1'b1;
      step();
      check_out("co_status", 1'b1, 4'b0001);
      read_data("co_data");
      ack = 1'b0;
      release_key();

      // Reset during HOLD, then during DEBOUNCE.
      press_key(2'd0, 2'd1);
      tick_step();
      step();
      do_reset();
      ticks(DEBOUNCE_CNT + 1);
      check_out("rst_hold_status", 1'b1, 4'h0);
      check_out("rst_hold_data", 1'b0, 4'h0);
      wait_row(4'b1101);
      key_row  = 2'd1;
      key_col  = 2'd0;
      key_down = 1'b1;
      tick_step();
      step();
      do_reset();
      ticks(4);
      check_out("rst_deb_status", 1'b1, 4'h0);
      check_out("rst_deb_data", 1'b0, 4'h0);

`ifdef KEYPAD_AUTOREPEAT_EN
      // Auto-repeat every REPEAT_TICKS ticks of continuous hold.
      exp_q.push_back(4'h5);
      press_key(2'd1, 2'd1);
      check_out("ar_latch", 1'b1, 4'b0001);
      read_data("ar_data");
      ticks(REPEAT_TICKS - 1);
      check_out("ar_before_rep", 1'b1, 4'b0001);
      tick_step();
      check_out("ar_rep1", 1'b1, 4'b0011);
      ack_pulse();
      check_out("ar_ack", 1'b1, 4'h0);
      ticks(4);
      check_out("ar_before_rep2", 1'b1, 4'h0);
      tick_step();
      check_out("ar_rep2", 1'b1, 4'b0001);
      ticks(REPEAT_TICKS);
      check_out("ar_rep3", 1'b1, 4'b0011);
      check_out("ar_rep_data", 1'b0, 4'h5);
      release_key();
`endif

      chk("sb_drain", 4'(exp_q.size()), 4'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
